unidade_controle_jogo: RTL
==========================

Name: unidade_controle_jogo

Overview:
Moore FSM that sequences the memory-game datapath (address/round counters, play register, timeout counter, sync RAM, comparators).
- Per round, it walks addresses 0..rodada, waits for each play, registers it and compares it with memory.
- It advances address or round, and ends in win, loss or timeout.
- Sits beside the datapath in the top-level game module; all datapath control strobes originate here.

Parameters:
DB_ESTADO_W, 4, width of db_estado debug output (must be >= 4)

Ports:
clock  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous active-high reset
iniciar  input  1  start/restart request, level-sampled
jogada_feita  input  1  one-cycle pulse from datapath edge detector
igual  input  1  registered play equals memory data
enderecoIgualRodada  input  1  address counter == round counter
fimRod  input  1  round counter at 15 (RCO)
fimT  input  1  timeout counter reached end
zeraE  output  1  clear address counter
contaE  output  1  increment address counter
zeraRod  output  1  clear round counter
contaRod  output  1  increment round counter
zeraR  output  1  clear play register
registraR  output  1  load play register
zeraT  output  1  clear timeout counter
contaT  output  1  enable timeout counter
pronto  output  1  game finished (any outcome)
acertou  output  1  game won
errou  output  1  wrong play
timeout  output  1  play window expired
db_estado  output  DB_ESTADO_W  current state code, zero-extended

Behaviour:
- Pure Moore: every output is decoded from the state register only; no input-to-output paths.
- State encodings, with outputs asserted in each state (all others 0):
  - inicial (0): no outputs.
  - preparacao (1): zeraE, zeraRod, zeraR, zeraT.
  - inicio_rodada (2): zeraE, zeraT.
  - espera_jogada (3): contaT.
  - registra (4): registraR, zeraT.
  - comparacao (5): no outputs.
  - proximo_endereco (6): contaE.
  - proxima_rodada (7): contaRod.
  - fim_acerto (A): pronto, acertou.
  - fim_erro (E): pronto, errou.
  - fim_timeout (B): pronto, timeout.
- Transitions:
  - inicial -> preparacao if iniciar.
  - preparacao -> inicio_rodada -> espera_jogada (unconditional).
  - espera_jogada -> registra on jogada_feita; else -> fim_timeout on fimT; else stay.
  - registra -> comparacao (unconditional).
  - comparacao:
    - !igual -> fim_erro.
    - igual & !enderecoIgualRodada -> proximo_endereco.
    - igual & enderecoIgualRodada & !fimRod -> proxima_rodada.
    - igual & enderecoIgualRodada & fimRod -> fim_acerto.
  - proximo_endereco -> espera_jogada.
  - proxima_rodada -> inicio_rodada.
  - fim_* -> preparacao if iniciar, else hold.
- Latency: a play pulse is registered 1 cycle after the FSM leaves espera_jogada; igual is evaluated in comparacao, i.e. 2 cycles after the jogada_feita edge.
- Simultaneous jogada_feita and fimT in espera_jogada: the play wins (-> registra).
- iniciar is ignored in every state except inicial and fim_*.
- Reset, including mid-game: state = inicial on the next edge; all outputs 0 and db_estado = 0 from that edge on.
- Unused encodings (8, 9, C, D, F): next state = inicial; outputs all 0.
- A full win is 16 rounds: round 0 has 1 play, round 15 has 16 plays.

Optional Feature:
TIMEOUT_EN
- Defined: behaviour as above (contaT asserted in espera_jogada; fimT -> fim_timeout).
- Undefined:
  - contaT is tied 0, fimT is ignored and fim_timeout is unreachable.
  - timeout output is constant 0.
  - espera_jogada waits indefinitely for jogada_feita.

Decomposition:
- Shared package: state encoding localparams (INICIAL..FIM_TIMEOUT, 4-bit) and ESTADO_W = 4, reused by the top level and the hex debug display decoding.
- No sub-module: one state register plus next-state logic plus output decode in a single module.

Test Plan:
- reset=1 for 2 cycles -> db_estado=0, all strobes and flags 0; iniciar=1 -> state 1 with zeraE=zeraRod=zeraR=zeraT=1, then states 2 and 3.
- Round 0 correct play (igual=1, enderecoIgualRodada=1, fimRod=0, one jogada_feita pulse) -> sequence 3, 4, 5, 7, 2, 3 with registraR and contaRod each high for exactly 1 cycle.
- Round 2, first play correct with enderecoIgualRodada=0 -> 5 -> 6 (contaE 1 cycle) -> 3.
- Wrong play (igual=0 in comparacao) -> state E with errou=pronto=1 held; iniciar=1 -> state 1.
- Last play with fimRod=1, igual=1, enderecoIgualRodada=1 -> state A with acertou=pronto=1.
- With TIMEOUT_EN: fimT=1 in state 3 -> state B, timeout=1.
  - fimT and jogada_feita in the same cycle -> state 4.
  - reset asserted in state 6 -> state 0 on the next edge.

Source files
------------

// File: rtl/unidade_controle_jogo_pkg.sv
// Shared state encoding and control-strobe bundle for the memory-game controller.
// Also used by the top-level hex debug display to decode db_estado.
package unidade_controle_jogo_pkg;

    localparam int ESTADO_W = 4;

    localparam logic [ESTADO_W-1:0] INICIAL          = 4'h0;
    localparam logic [ESTADO_W-1:0] PREPARACAO       = 4'h1;
    localparam logic [ESTADO_W-1:0] INICIO_RODADA    = 4'h2;
    localparam logic [ESTADO_W-1:0] ESPERA_JOGADA    = 4'h3;
    localparam logic [ESTADO_W-1:0] REGISTRA         = 4'h4;
    localparam logic [ESTADO_W-1:0] COMPARACAO       = 4'h5;
    localparam logic [ESTADO_W-1:0] PROXIMO_ENDERECO = 4'h6;
    localparam logic [ESTADO_W-1:0] PROXIMA_RODADA   = 4'h7;
    localparam logic [ESTADO_W-1:0] FIM_ACERTO       = 4'hA;
    localparam logic [ESTADO_W-1:0] FIM_TIMEOUT      = 4'hB;
    localparam logic [ESTADO_W-1:0] FIM_ERRO         = 4'hE;

    typedef struct packed {
        logic zera_e;
        logic conta_e;
        logic zera_rod;
        logic conta_rod;
        logic zera_r;
        logic registra_r;
        logic zera_t;
        logic conta_t;
        logic pronto;
        logic acertou;
        logic errou;
        logic timeout;
    } ctrl_t;

    // Terminal states all restart the game the same way on iniciar.
    function automatic logic is_fim(input logic [ESTADO_W-1:0] estado);
        return (estado == FIM_ACERTO) || (estado == FIM_ERRO) || (estado == FIM_TIMEOUT);
    endfunction

endpackage

// File: rtl/unidade_controle_jogo.sv
// Moore FSM sequencing the memory-game datapath; every output decodes from the state register.
// Optional play-window timeout enabled by defining TIMEOUT_EN; otherwise espera_jogada waits forever.
module unidade_controle_jogo
    import unidade_controle_jogo_pkg::*;
#(
    parameter int DB_ESTADO_W = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iniciar,
    input  logic                   jogada_feita,
    input  logic                   igual,
    input  logic                   enderecoIgualRodada,
    input  logic                   fimRod,
    input  logic                   fimT,
    output logic                   zeraE,
    output logic                   contaE,
    output logic                   zeraRod,
    output logic                   contaRod,
    output logic                   zeraR,
    output logic                   registraR,
    output logic                   zeraT,
    output logic                   contaT,
    output logic                   pronto,
    output logic                   acertou,
    output logic                   errou,
    output logic                   timeout,
    output logic [DB_ESTADO_W-1:0] db_estado
);

    logic [ESTADO_W-1:0] estado_q;
    logic [ESTADO_W-1:0] estado_d;
    ctrl_t               ctrl;
    logic                fim_t_ok;

`ifdef TIMEOUT_EN
    assign fim_t_ok = fimT;
`else
    logic unused_fimt;
    assign unused_fimt = fimT;
    assign fim_t_ok    = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = INICIAL;
        case (estado_q)
            INICIAL:          estado_d = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:       estado_d = INICIO_RODADA;
            INICIO_RODADA:    estado_d = ESPERA_JOGADA;
            // A play arriving together with the timeout still counts.
            ESPERA_JOGADA: begin
                if (jogada_feita)  estado_d = REGISTRA;
                else if (fim_t_ok) estado_d = FIM_TIMEOUT;
                else               estado_d = ESPERA_JOGADA;
            end
            REGISTRA:         estado_d = COMPARACAO;
            COMPARACAO: begin
                if (!igual)                    estado_d = FIM_ERRO;
                else if (!enderecoIgualRodada) estado_d = PROXIMO_ENDERECO;
                else if (!fimRod)              estado_d = PROXIMA_RODADA;
                else                           estado_d = FIM_ACERTO;
            end
            PROXIMO_ENDERECO: estado_d = ESPERA_JOGADA;
            PROXIMA_RODADA:   estado_d = INICIO_RODADA;
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
                estado_d = iniciar ? PREPARACAO : estado_q;
            default:          estado_d = INICIAL;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (estado_q)
            PREPARACAO: begin
                ctrl.zera_e   = 1'b1;
                ctrl.zera_rod = 1'b1;
                ctrl.zera_r   = 1'b1;
                ctrl.zera_t   = 1'b1;
            end
            INICIO_RODADA: begin
                ctrl.zera_e = 1'b1;
                ctrl.zera_t = 1'b1;
            end
`ifdef TIMEOUT_EN
            ESPERA_JOGADA:    ctrl.conta_t = 1'b1;
`endif
            REGISTRA: begin
                ctrl.registra_r = 1'b1;
                ctrl.zera_t     = 1'b1;
            end
            PROXIMO_ENDERECO: ctrl.conta_e   = 1'b1;
            PROXIMA_RODADA:   ctrl.conta_rod = 1'b1;
            FIM_ACERTO: begin
                ctrl.pronto  = 1'b1;
                ctrl.acertou = 1'b1;
            end
            FIM_ERRO: begin
                ctrl.pronto = 1'b1;
                ctrl.errou  = 1'b1;
            end
`ifdef TIMEOUT_EN
            FIM_TIMEOUT: begin
                ctrl.pronto  = 1'b1;
                ctrl.timeout = 1'b1;
            end
`endif
            default:          ctrl = '0;
        endcase
    end

    assign zeraE     = ctrl.zera_e;
    assign contaE    = ctrl.conta_e;
    assign zeraRod   = ctrl.zera_rod;
    assign contaRod  = ctrl.conta_rod;
    assign zeraR     = ctrl.zera_r;
    assign registraR = ctrl.registra_r;
    assign zeraT     = ctrl.zera_t;
    assign contaT    = ctrl.conta_t;
    assign pronto    = ctrl.pronto;
    assign acertou   = ctrl.acertou;
    assign errou     = ctrl.errou;
    assign timeout   = ctrl.timeout;

    always_comb begin
        db_estado                 = '0;
        db_estado[ESTADO_W-1:0]   = estado_q;
    end

endmodule
